cordic_atan_unroll1: RTL and testbench

Iterative CORDIC arctangent unit, the vectoring-mode counterpart of the rotation-mode cosine unit. It sits behind the same custom-instruction handshake (start/clk_en/done). It accepts an FP32 operand t and returns FP32 atan(t), one CORDIC micro-rotation per clock. It exploits odd symmetry: it computes atan(|t|) and reapplies the input sign.

---
 rtl/cordic_pkg.sv | 26 ++
 rtl/atan_fix_to_float.sv | 30 +++
 rtl/cordic_atan_unroll1.sv | 133 +++++++++++++
 tb/tb_cordic_atan_unroll1.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, arctangent table and FSM states for the CORDIC units
package cordic_pkg;

  localparam int WL     = 21;
  localparam int FRAC   = 20;
  localparam int N_ITER = 16;
  localparam int CNT_W  = 4;

  // Initial x for vectoring mode: 0.25 in Q1.20, so y0 = |t|/4 keeps the ratio y/x = |t|
  localparam logic [WL-1:0] X0_ATAN = 21'h040000;

  // round(atan(2^-i) * 2^20), i = 0..15
  localparam logic [WL-1:0] ATAN_LUT [N_ITER] = '{
    21'h0c90fe, 21'h076b1a, 21'h03eb6f, 21'h01fd5c,
    21'h00ffab, 21'h007ff5, 21'h003fff, 21'h002000,
    21'h001000, 21'h000800, 21'h000400, 21'h000200,
    21'h000100, 21'h000080, 21'h000040, 21'h000020
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/atan_fix_to_float.sv
// rtl/atan_fix_to_float.sv - Q1.20 magnitude plus sign to FP32 normalizer (truncating)
module atan_fix_to_float
  import cordic_pkg::*;
(
  input  logic [WL-1:0] fix_i,
  input  logic          sign_i,
  output logic [31:0]   fp_o
);

  logic [FRAC-1:0] mag;
  logic [4:0]      lead;
  logic [22:0]     mant;

  // Clamp negatives to zero, find the leading one, left-align the bits below it
  always_comb begin
    mag  = fix_i[WL-1] ? '0 : fix_i[FRAC-1:0];
    lead = 5'd0;
    for (int i = 0; i < FRAC; i++) begin
      if (mag[i]) lead = 5'(i);
    end
    // Shifting the leading one up to bit 23 pushes it out of the 23-bit field
    mant = 23'(mag) << (5'd23 - lead);
    if (mag == '0) begin
      fp_o = 32'h0000_0000;
    end else begin
      fp_o = {sign_i, 8'd107 + {3'b000, lead}, mant};
    end
  end

endmodule

// File: rtl/cordic_atan_unroll1.sv
// rtl/cordic_atan_unroll1.sv - iterative vectoring-mode CORDIC atan, one micro-rotation per clock
module cordic_atan_unroll1
  import cordic_pkg::*;
(
  input  logic        clock,
  input  logic        aclr_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic signed [WL-1:0]  x_q, x_d;
  logic signed [WL-1:0]  y_q, y_d;
  logic signed [WL-1:0]  z_q, z_d;
  logic                  sign_q, sign_d;
  logic [31:0]           result_q, result_d;

  logic [7:0]            exp_in;
  logic [7:0]            sh;
  logic [23:0]           m24;
  logic [WL-1:0]         y0;

  logic signed [WL-1:0]  xs, ys, lut;
  logic signed [WL-1:0]  x_it, y_it, z_it;
  logic [31:0]           fp_res;

  // FP32 |t| to |t|/4 in Q1.20; |t| >= 1 and NaN/Inf saturate to 0.25 (angle pi/4)
  always_comb begin
    exp_in = dataa[30:23];
    m24    = {1'b1, dataa[22:0]};
    sh     = 8'd132 - exp_in;
    y0     = '0;
    if (exp_in == 8'd0) begin
      y0 = '0;
    end else if (exp_in >= 8'd127) begin
      y0 = X0_ATAN;
    end else if (sh < 8'd24) begin
      y0 = 21'(m24 >> sh);
    end
  end

  // One micro-rotation driving y toward zero while z accumulates the angle
  always_comb begin
    xs  = x_q >>> cnt_q;
    ys  = y_q >>> cnt_q;
    lut = $signed(ATAN_LUT[cnt_q]);
    if (!y_q[WL-1]) begin
      x_it = x_q + ys;
      y_it = y_q - xs;
      z_it = z_q + lut;
    end else begin
      x_it = x_q - ys;
      y_it = y_q + xs;
      z_it = z_q - lut;
    end
  end

  atan_fix_to_float u_fix_to_float (
    .fix_i  (z_it),
    .sign_i (sign_q),
    .fp_o   (fp_res)
  );

  // Next-state logic: load on accepted start, iterate 16 times, one DONE cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    sign_d   = sign_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ITER;
          cnt_d   = '0;
          x_d     = X0_ATAN;
          y_d     = y0;
          z_d     = '0;
          sign_d  = dataa[31];
        end
      end
      ITER: begin
        x_d   = x_it;
        y_d   = y_it;
        z_d   = z_it;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_ITER - 1)) begin
          state_d  = DONE;
          result_d = fp_res;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; clk_en low freezes everything, including the done state
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      sign_q   <= 1'b0;
      result_q <= 32'h0000_0000;
    end else if (clk_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign done   = (state_q == DONE);
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_atan_unroll1.sv
// tb/tb_cordic_atan_unroll1.sv - self-checking bench for cordic_atan_unroll1
module tb_cordic_atan_unroll1;

  logic        clock;
  logic        aclr_n;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;
  logic        busy;

  int n_tests;
  int n_fail;

  localparam real TOL = 1.0 / 16384.0;

  cordic_atan_unroll1 dut (
    .clock  (clock),
    .aclr_n (aclr_n),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic real fp2real(input logic [31:0] f);
    real v;
    int  e;
    e = int'(f[30:23]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(f[22:0]) / 8388608.0;
    while (e > 127) begin v = v * 2.0; e--; end
    while (e < 127) begin v = v / 2.0; e++; end
    return f[31] ? -v : v;
  endfunction

  // atan(t) with magnitudes at or above 1 (and NaN/Inf) saturated to atan(1)
  function automatic real ref_atan(input logic [31:0] t);
    real a;
    logic [31:0] tm;
    tm = {1'b0, t[30:0]};
    a  = (t[30:23] >= 8'd127) ? 1.0 : fp2real(tm);
    a  = $atan(a);
    return t[31] ? -a : a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] res, input logic [31:0] t);
    real r, g, err;
    logic ok;
    r   = ref_atan(t);
    g   = fp2real(res);
    err = (g > r) ? (g - r) : (r - g);
    ok  = (err <= TOL);
    n_tests++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s t=%h observed=%h (%g) expected=%g err=%g", tag, t, res, g, r, err);
    end
  endtask

  // Launch one operation; optional clk_en stall; extra starts while busy and at done
  task automatic run_op(input string tag, input logic [31:0] t, input int stall_at,
                        input int stall_len, input int exp_lat, output logic [31:0] res);
    int   cyc;
    logic seen;
    logic busy_ok;
    @(negedge clock);
    start = 1'b1;
    dataa = t;
    cyc     = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && cyc < 200) begin
      @(negedge clock);
      if (cyc > 0 && busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) seen = 1'b1;
      else begin
        cyc++;
        if (cyc == 3 || cyc == 14) begin start = 1'b1; dataa = $urandom; end
        else begin start = 1'b0; dataa = $urandom; end
        if (cyc == stall_at) clk_en = 1'b0;
        if (cyc == stall_at + stall_len) clk_en = 1'b1;
      end
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_busy"}, {31'b0, busy_ok}, 32'h1);
    res = result;
    // start coincident with done must be ignored
    start = 1'b1;
    dataa = $urandom;
    @(negedge clock);
    start = 1'b0;
    chk({tag, "_done_width"}, {30'b0, done, busy}, 32'h0);
    repeat ($urandom_range(0, 2)) @(negedge clock);
    chk({tag, "_stable"}, result, res);
  endtask

  logic [31:0] res_a, res_b, t;
  logic        done_seen;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    aclr_n  = 1'b0;
    clk_en  = 1'b1;
    start   = 1'b0;
    dataa   = 32'h0;
    repeat (2) @(negedge clock);
    chk("reset_state", {result[31:0]}, 32'h0);
    chk("reset_flags", {30'b0, done, busy}, 32'h0);
    aclr_n = 1'b1;
    @(negedge clock);

    run_op("t_one", 32'h3F800000, -1, 0, 16, res_a);
    chk_tol("t_one_val", res_a, 32'h3F800000);

    run_op("t_mhalf", 32'hBF000000, -1, 0, 16, res_a);
    chk_tol("t_mhalf_val", res_a, 32'hBF000000);
    chk("t_mhalf_sign", {31'b0, res_a[31]}, 32'h1);

    run_op("t_three", 32'h40400000, -1, 0, 16, res_a);
    chk_tol("t_three_val", res_a, 32'h40400000);
    run_op("t_zero", 32'h00000000, -1, 0, 16, res_a);
    chk_tol("t_zero_val", res_a, 32'h00000000);

    run_op("t_qtr", 32'h3E800000, -1, 0, 16, res_a);
    chk_tol("t_qtr_val", res_a, 32'h3E800000);
    run_op("t_qtr_stall", 32'h3E800000, 7, 5, 21, res_b);
    chk("t_qtr_stall_same", res_b, res_a);

    // Asynchronous abort at cnt=8
    @(negedge clock);
    start = 1'b1;
    dataa = 32'h3F666666;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    aclr_n = 1'b0;
    #1;
    chk("abort_result", result, 32'h0);
    chk("abort_flags", {30'b0, done, busy}, 32'h0);
    @(negedge clock);
    aclr_n    = 1'b1;
    done_seen = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (done === 1'b1) done_seen = 1'b1;
    end
    chk("abort_no_done", {31'b0, done_seen}, 32'h0);

    run_op("t_075", 32'h3F400000, -1, 0, 16, res_a);
    chk_tol("t_075_val", res_a, 32'h3F400000);

    for (int k = 0; k < 1000; k++) begin
      logic [7:0] e;
      e = 8'(100 + $urandom_range(0, 27));
      t = {1'($urandom), e, (e == 8'd127) ? 23'h0 : 23'($urandom)};
      run_op("sweep", t, -1, 0, 16, res_a);
      chk_tol("sweep_val", res_a, t);
      if (res_a != 32'h0) chk("sweep_sign", {31'b0, res_a[31]}, {31'b0, t[31]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
